// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encodings,
// default image depth and small state-classification helpers.
package imem_boot_loader_pkg;

  localparam int BOOT_DEPTH = 64;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_CHK     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  function automatic logic is_busy(input logic [2:0] st);
    return (st == S_COLLECT) || (st == S_WRITE) || (st == S_CHK);
  endfunction

  function automatic logic is_rx_state(input logic [2:0] st);
    return (st == S_IDLE) || (st == S_COLLECT) || (st == S_CHK);
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-serial valid/ready stream feeding the boot loader.
interface imem_boot_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// boot_word_assembler: packs payload bytes little-endian into 32-bit words
// and keeps the running XOR checksum of the frame.
module boot_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic        clk_mips,
  input  logic        rst_pc,
  input  logic        init,
  input  logic        shift,
  input  logic [7:0]  rx_byte,
  output logic [31:0] word,
  output logic        word_ready,
  output logic [7:0]  csum
);

  logic [1:0]  byte_idx;
  logic [31:0] word_q;

  // word already contains the byte being accepted, so the top can register it
  // on the same edge as the 4th transfer.
  always_comb begin
    word = word_q;
    word[{byte_idx, 3'b000} +: 8] = rx_byte;
  end

  assign word_ready = shift && (byte_idx == 2'd3);

  always_ff @(posedge clk_mips) begin
    if (!rst_pc) begin
      byte_idx <= '0;
      word_q   <= '0;
      csum     <= '0;
    end else if (init) begin
      byte_idx <= '0;
      word_q   <= '0;
      csum     <= rx_byte;
    end else if (shift) begin
      word_q   <= word;
      csum     <= csum ^ rx_byte;
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a COUNT/payload/CHK frame, writes it into instruction
// memory and releases the MIPS core reset only after the checksum matches.
//
//  state   | meaning
//  IDLE    | waiting for the COUNT byte
//  COLLECT | accepting the 4 bytes of the current word
//  WRITE   | one-cycle imem write, stream stalled
//  CHK     | waiting for the checksum byte
//  DONE    | image verified, core released
//  ERR     | bad count, bad checksum or timeout; core held in reset
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = BOOT_DEPTH,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_mips,
  input  logic              rst_pc,
  imem_boot_loader_if.slave rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_RELOAD = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [8:0] DEPTH_B = 9'(DEPTH);

  logic [2:0]        state, state_nxt;
  logic              xfer, count_ok, to_hit;
  logic              asm_init, asm_shift, word_ready;
  logic [31:0]       asm_word;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] word_addr, last_addr;
  logic [TO_W-1:0]   to_cnt;

  assign xfer      = rx.rx_valid & rx.rx_ready;
  assign count_ok  = (rx.rx_data != 8'd0) && ({1'b0, rx.rx_data} <= DEPTH_B);
  assign to_hit    = (TIMEOUT_CYC != 0) && (to_cnt == '0);
  assign asm_init  = xfer && (state == S_IDLE) && count_ok;
  assign asm_shift = xfer && (state == S_COLLECT);

  boot_word_assembler u_asm (
    .clk_mips   (clk_mips),
    .rst_pc     (rst_pc),
    .init       (asm_init),
    .shift      (asm_shift),
    .rx_byte    (rx.rx_data),
    .word       (asm_word),
    .word_ready (word_ready),
    .csum       (csum)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (xfer) state_nxt = count_ok ? S_COLLECT : S_ERR;
      S_COLLECT: begin
        if (word_ready)  state_nxt = S_WRITE;
        else if (!xfer && to_hit) state_nxt = S_ERR;
      end
      S_WRITE:   state_nxt = (word_addr == last_addr) ? S_CHK : S_COLLECT;
      S_CHK: begin
        if (xfer)        state_nxt = (rx.rx_data == csum) ? S_DONE : S_ERR;
        else if (to_hit) state_nxt = S_ERR;
      end
      S_DONE:    state_nxt = S_DONE;
      S_ERR:     state_nxt = S_ERR;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_mips) begin
    if (!rst_pc) begin
      state       <= S_IDLE;
      rx.rx_ready <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      cpu_rst_n   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      word_addr   <= '0;
      last_addr   <= '0;
      to_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      rx.rx_ready <= is_rx_state(state_nxt);
      busy        <= is_busy(state_nxt);
      done        <= (state_nxt == S_DONE);
      err         <= (state_nxt == S_ERR);
      cpu_rst_n   <= (state == S_DONE);
      imem_we     <= word_ready;
      if (word_ready) begin
        imem_addr  <= word_addr;
        imem_wdata <= asm_word;
      end
      if (asm_init) begin
        word_addr <= '0;
        last_addr <= ADDR_W'(rx.rx_data - 8'd1);
      end else if ((state == S_WRITE) && (word_addr != last_addr)) begin
        word_addr <= word_addr + ADDR_W'(1);
      end
      if (xfer)
        to_cnt <= TO_RELOAD;
      else if (((state == S_COLLECT) || (state == S_CHK)) && (to_cnt != '0))
        to_cnt <= to_cnt - TO_W'(1);
    end
  end

endmodule
